// File: rtl/eeprom_rtc_pkg.sv
// Shared definitions for the serial EEPROM/RTC target: FSM encoding and byte framing constants.
package eeprom_rtc_pkg;

  localparam int CMD_READ_BIT = 7;
  localparam int BYTE_BITS    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

endpackage

// File: rtl/eeprom_rtc_ser_sync.sv
// Multi-flop synchronizer for one serial input plus rise/fall detection on the synchronized level.
module ser_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_reg;
  logic              prev_reg;

  // Shift form keeps a single-stage build legal as well.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chain_reg <= '0;
      prev_reg  <= 1'b0;
    end else begin
      chain_reg <= (chain_reg << 1) | STAGES'(din);
      prev_reg  <= chain_reg[STAGES-1];
    end
  end

  assign level = chain_reg[STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/eeprom_rtc_target.sv
// Serial byte-addressed memory target with a write-protect control register at the top address.
module eeprom_rtc_target
  import eeprom_rtc_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic ser_ce,
  input  logic ser_clk,
  input  logic ser_di,
  output logic ser_do,
  output logic busy
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = '1;

  // Index 0 = ce, 1 = clk, 2 = di.
  logic [2:0] sync_in;
  logic [2:0] sync_level;
  logic [2:0] sync_rise;
  logic [2:0] sync_fall;

  assign sync_in = {ser_di, ser_clk, ser_ce};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    ser_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clock (clock),
      .reset (reset),
      .din   (sync_in[gi]),
      .level (sync_level[gi]),
      .rise  (sync_rise[gi]),
      .fall  (sync_fall[gi])
    );
  end

  logic ce_level, ce_rise, clk_rise, clk_fall, di_level;
  logic unused_sync;

  assign ce_level    = sync_level[0];
  assign ce_rise     = sync_rise[0];
  assign clk_rise    = sync_rise[1];
  assign clk_fall    = sync_fall[1];
  assign di_level    = sync_level[2];
  assign unused_sync = &{1'b0, sync_fall[0], sync_level[1], sync_rise[2], sync_fall[2]};

  state_t                 state_reg;
  logic [2:0]             bit_cnt_reg;
  logic [BYTE_BITS-1:0]   shift_reg;
  logic [ADDR_W-1:0]      addr_reg;
  logic                   wp_reg;
  logic [1:0]             load_phase_reg;
  logic [BYTE_BITS-1:0]   rd_data_reg;
  logic [BYTE_BITS-1:0]   mem [DEPTH];

  logic [BYTE_BITS-1:0] byte_in;
  logic                 last_bit;
  logic                 mem_we;
  logic                 mem_re;

  assign byte_in  = {shift_reg[BYTE_BITS-2:0], di_level};
  assign last_bit = (bit_cnt_reg == 3'd7);

  // Gated by ce_level so an abort landing on the 8th edge never writes.
  assign mem_we = ce_level && (state_reg == WDATA) && clk_rise && last_bit &&
                  (addr_reg != CTRL_ADDR) && !wp_reg;
  assign mem_re = (state_reg == RDATA) && (load_phase_reg == 2'd1);

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[addr_reg] <= byte_in;
    end else if (mem_re) begin
      rd_data_reg <= mem[addr_reg];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      addr_reg       <= '0;
      wp_reg         <= 1'b0;
      load_phase_reg <= '0;
    end else if (state_reg != IDLE && !ce_level) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      load_phase_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ce_rise) begin
            state_reg   <= CMD;
            bit_cnt_reg <= '0;
          end
        end
        CMD: begin
          if (clk_rise) begin
            shift_reg   <= byte_in;
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (last_bit) begin
              addr_reg <= byte_in[ADDR_W-1:0];
              if (byte_in[CMD_READ_BIT]) begin
                state_reg      <= RDATA;
                load_phase_reg <= 2'd1;
              end else begin
                state_reg <= WDATA;
              end
            end
          end
        end
        WDATA: begin
          if (clk_rise) begin
            shift_reg   <= byte_in;
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (last_bit) begin
              if (addr_reg == CTRL_ADDR) begin
                wp_reg <= byte_in[0];
              end
              addr_reg <= addr_reg + ADDR_W'(1);
            end
          end
        end
        RDATA: begin
          // Phase 1 issues the RAM read, phase 2 captures it, phase 0 shifts.
          case (load_phase_reg)
            2'd1: load_phase_reg <= 2'd2;
            2'd2: begin
              shift_reg      <= (addr_reg == CTRL_ADDR) ? {{(BYTE_BITS-1){1'b0}}, wp_reg}
                                                        : rd_data_reg;
              bit_cnt_reg    <= '0;
              load_phase_reg <= 2'd0;
            end
            default: begin
              if (clk_fall) begin
                shift_reg   <= {shift_reg[BYTE_BITS-2:0], 1'b0};
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                if (last_bit) begin
                  addr_reg       <= addr_reg + ADDR_W'(1);
                  load_phase_reg <= 2'd1;
                end
              end
            end
          endcase
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ser_do = (state_reg == RDATA && load_phase_reg == 2'd0) ? shift_reg[BYTE_BITS-1] : 1'b1;
  assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_eeprom_rtc_target.sv
// Scoreboard bench: frames are driven at transaction level and read bytes are checked by a bus monitor.
module tb_eeprom_rtc_target;

  localparam int ADDR_W      = 7;
  localparam int SYNC_STAGES = 2;
  localparam int DEPTH       = 1 << ADDR_W;
  localparam int HALF        = 8;

  logic clock   = 1'b0;
  logic reset   = 1'b0;
  logic ser_ce  = 1'b0;
  logic ser_clk = 1'b0;
  logic ser_di  = 1'b0;
  logic ser_do;
  logic busy;

  always #5 clock = ~clock;

  eeprom_rtc_target #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clock   (clock),
    .reset   (reset),
    .ser_ce  (ser_ce),
    .ser_clk (ser_clk),
    .ser_di  (ser_di),
    .ser_do  (ser_do),
    .busy    (busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] ref_mem [DEPTH];
  logic       ref_wp = 1'b0;
  logic [7:0] exp_q [$];
  logic [7:0] wq [$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %02h want %02h at %0t", name, act, req, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic ser_bit(input logic d);
    ser_di = d;
    wait_clks(HALF);
    ser_clk = 1'b1;
    wait_clks(HALF);
    ser_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) ser_bit(b[i]);
  endtask

  task automatic frame_open;
    ser_ce = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic frame_close;
    wait_clks(HALF);
    ser_ce = 1'b0;
    wait_clks(2 * HALF);
  endtask

  // Reference behaviour of one stored byte: control address sets WP, others honour WP.
  task automatic model_write(inout int a, input logic [7:0] d);
    if (a == DEPTH - 1) ref_wp = d[0];
    else if (!ref_wp) ref_mem[a] = d;
    a = (a + 1) % DEPTH;
  endtask

  task automatic wr_frame(input int a);
    int ma;
    ma = a;
    frame_open();
    send_byte(8'(a));
    foreach (wq[i]) begin
      send_byte(wq[i]);
      model_write(ma, wq[i]);
    end
    frame_close();
  endtask

  task automatic rd_frame(input int a, input int n);
    int ma;
    ma = a;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back((ma == DEPTH - 1) ? {7'b0, ref_wp} : ref_mem[ma]);
      ma = (ma + 1) % DEPTH;
    end
    frame_open();
    send_byte(8'h80 | 8'(a));
    repeat (8 * n - 1) ser_bit(1'b0);
    frame_close();
  endtask

  // full complete bytes, then either k bits of a partial byte or an abort on its 8th edge.
  task automatic abort_wr(input int a, input int full, input int k, input bit coincide);
    int         ma;
    logic [7:0] d;
    ma = a;
    frame_open();
    send_byte(8'(a));
    for (int j = 0; j < full; j++) begin
      d = 8'($urandom);
      send_byte(d);
      model_write(ma, d);
    end
    d = 8'($urandom);
    if (coincide) begin
      for (int i = 7; i >= 1; i--) ser_bit(d[i]);
      ser_di = d[0];
      wait_clks(HALF);
      ser_ce  = 1'b0;
      ser_clk = 1'b1;
      wait_clks(HALF);
      ser_clk = 1'b0;
    end else begin
      for (int i = 7; i > 7 - k; i--) ser_bit(d[i]);
      wait_clks(2);
      ser_ce = 1'b0;
    end
    wait_clks(SYNC_STAGES + 2);
    check("abort_busy", {7'b0, busy}, 8'h00);
    check("abort_do", {7'b0, ser_do}, 8'h01);
    wait_clks(2 * HALF);
  endtask

  // Bus monitor: decodes the command from ser_di and samples ser_do just before each falling ser_clk.
  initial begin
    logic [7:0] cmd;
    logic [7:0] got;
    int         nr;
    int         nb;
    cmd = '0; got = '0; nr = 0; nb = 0;
    forever begin
      @(ser_clk or negedge ser_ce);
      if (!ser_ce) begin
        nr = 0;
        nb = 0;
      end else if (ser_clk) begin
        if (nr < 8) begin
          cmd = {cmd[6:0], ser_di};
          nr++;
        end
      end else if (nr == 8 && cmd[7]) begin
        got = {got[6:0], ser_do};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL read_byte: got %02h want none (queue empty)", got);
          end else begin
            check("read_byte", got, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #900us;
    $display("FAIL timeout: got running want finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int a;
    int n;
    int op;

    wait_clks(3);
    check("reset_busy", {7'b0, busy}, 8'h00);
    check("reset_do", {7'b0, ser_do}, 8'h01);
    reset = 1'b1;
    wait_clks(4);

    // Write then read back one byte.
    wq = {};
    wq.push_back(8'hA5);
    wr_frame(8'h05);
    rd_frame(8'h05, 1);

    // Burst across the control register and wrap to address 0.
    wq = {};
    wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33);
    wr_frame(8'h7E);
    rd_frame(8'h7E, 3);

    // Fill every data location so later random reads have known contents.
    wq = {};
    for (int i = 0; i < DEPTH - 1; i++) wq.push_back(8'($urandom));
    wr_frame(0);

    // Write protect blocks data writes but not the control register.
    wq = {}; wq.push_back(8'h01); wr_frame(8'h7F);
    wq = {}; wq.push_back(8'hFF); wr_frame(8'h10);
    rd_frame(8'h10, 1);
    rd_frame(8'h7F, 1);
    wq = {}; wq.push_back(8'h00); wr_frame(8'h7F);

    // Abort after five data bits, then abort on the 8th edge itself.
    a = int'($urandom_range(0, DEPTH - 2));
    abort_wr(a, 0, 5, 1'b0);
    rd_frame(a, 1);
    a = int'($urandom_range(0, DEPTH - 3));
    abort_wr(a, 1, 0, 1'b1);
    rd_frame(a, 2);

    for (int t = 0; t < 30; t++) begin
      op = int'($urandom_range(0, 3));
      a  = int'($urandom_range(0, DEPTH - 1));
      case (op)
        0: begin
          n  = int'($urandom_range(1, 4));
          wq = {};
          for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
          wr_frame(a);
        end
        1: rd_frame(a, int'($urandom_range(1, 3)));
        2: begin
          abort_wr(a, int'($urandom_range(0, 2)), int'($urandom_range(1, 7)), 1'($urandom));
          rd_frame(a, 3);
        end
        default: begin
          repeat (3) begin
            ser_clk = 1'b1; wait_clks(HALF);
            ser_clk = 1'b0; wait_clks(HALF);
          end
          rd_frame(a, 2);
        end
      endcase
    end

    // Reset in the middle of a read frame.
    frame_open();
    send_byte(8'h85);
    ser_bit(1'b0);
    ser_bit(1'b0);
    ser_di = 1'b0;
    wait_clks(HALF);
    ser_clk = 1'b1;
    wait_clks(HALF / 2);
    reset = 1'b0;
    #1;
    check("midread_reset_do", {7'b0, ser_do}, 8'h01);
    check("midread_reset_busy", {7'b0, busy}, 8'h00);
    ser_ce = 1'b0;
    wait_clks(2);
    ser_clk = 1'b0;
    wait_clks(4);
    reset  = 1'b1;
    ref_wp = 1'b0;
    wait_clks(2 * HALF);
    rd_frame(8'h05, 2);
    rd_frame(8'h7F, 1);

    wait_clks(4 * HALF);
    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
